// File: rtl/td4_cpu_top_if.sv
`default_nettype none
// ============================================================================
// Module   : td4_cpu_top_if
// Brief    : Board I/O bundle of the TD4 CPU: switch input port and LED port.
// Revision : 1.0
// ============================================================================
interface td4_cpu_top_if;
    logic [3:0] sw;
    logic [3:0] LED;

    modport master (output sw, input LED);
    modport slave  (input sw, output LED);
endinterface
`default_nettype wire

// File: rtl/td4_cpu_top.sv
`default_nettype none
// ============================================================================
// Module   : td4_cpu_top
// Brief    : TD4-class 4-bit CPU, one instruction per clock, 16x8 internal ROM.
// Revision : 1.0
// ============================================================================
module td4_cpu_top #(
    parameter logic [127:0] PROGRAM = 128'h0000_0000_0000_0000_00F6_BFE1_0190_4020
) (
    input  wire logic     clock,
    input  wire logic     reset,
    td4_cpu_top_if.slave  io
);

    localparam logic [3:0] C_OP_ADD_A = 4'b0000;
    localparam logic [3:0] C_OP_MOV_AB = 4'b0001;
    localparam logic [3:0] C_OP_IN_A  = 4'b0010;
    localparam logic [3:0] C_OP_MOV_AI = 4'b0011;
    localparam logic [3:0] C_OP_MOV_BA = 4'b0100;
    localparam logic [3:0] C_OP_ADD_B = 4'b0101;
    localparam logic [3:0] C_OP_IN_B  = 4'b0110;
    localparam logic [3:0] C_OP_MOV_BI = 4'b0111;
    localparam logic [3:0] C_OP_OUT_B = 4'b1001;
    localparam logic [3:0] C_OP_OUT_I = 4'b1011;
    localparam logic [3:0] C_OP_JNC   = 4'b1110;
    localparam logic [3:0] C_OP_JMP   = 4'b1111;

    logic [3:0] r_a;
    logic [3:0] r_b;
    logic [3:0] r_out;
    logic [3:0] r_pc;
    logic       r_c;

    logic [7:0] w_instr;
    logic [3:0] w_op;
    logic [3:0] w_im;
    logic [3:0] w_src;
    logic [4:0] w_sum;

    assign w_instr = PROGRAM[{r_pc, 3'b000} +: 8];
    assign w_op    = w_instr[7:4];
    assign w_im    = w_instr[3:0];

    // Every opcode funnels through one adder; non-arithmetic ops add a zero source.
    always_comb begin
        w_src = 4'h0;
        case (w_op)
            C_OP_ADD_A, C_OP_MOV_BA:             w_src = r_a;
            C_OP_ADD_B, C_OP_MOV_AB, C_OP_OUT_B: w_src = r_b;
            C_OP_IN_A,  C_OP_IN_B:               w_src = io.sw;
            default:                             w_src = 4'h0;
        endcase
    end

    assign w_sum = {1'b0, w_src} + {1'b0, w_im};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_a   <= 4'h0;
            r_b   <= 4'h0;
            r_out <= 4'h0;
            r_pc  <= 4'h0;
            r_c   <= 1'b0;
        end else begin
            r_c  <= w_sum[4];
            r_pc <= r_pc + 4'd1;
            case (w_op)
                C_OP_ADD_A, C_OP_MOV_AB, C_OP_IN_A, C_OP_MOV_AI: r_a   <= w_sum[3:0];
                C_OP_MOV_BA, C_OP_ADD_B, C_OP_IN_B, C_OP_MOV_BI: r_b   <= w_sum[3:0];
                C_OP_OUT_B, C_OP_OUT_I:                          r_out <= w_sum[3:0];
                // Carry tested here is the one left by the previous instruction.
                C_OP_JNC: if (!r_c) r_pc <= w_im;
                C_OP_JMP: r_pc <= w_im;
                default: ;
            endcase
        end
    end

    assign io.LED = r_out;

endmodule
`default_nettype wire

// File: tb/tb_td4_cpu_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_td4_cpu_top
// Brief    : Self-checking bench for td4_cpu_top: default, custom and NOP ROMs.
// Revision : 1.0
// ============================================================================
module tb_td4_cpu_top;

    localparam logic [127:0] C_PROG_DEF  = 128'h0000_0000_0000_0000_00F6_BFE1_0190_4020;
    localparam logic [127:0] C_PROG_CUST = 128'h0000_0000_0000_0000_0000_0000_B5E0_033E;
    localparam logic [127:0] C_PROG_NOP  = 128'h0;

    typedef struct packed {
        logic [3:0] pc;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] out;
        logic       c;
    } st_t;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    st_t          m [3];
    logic [127:0] progs [3];
    st_t          exp_q [$];

    always #5 clock = ~clock;

    td4_cpu_top_if io0 ();
    td4_cpu_top_if io1 ();
    td4_cpu_top_if io2 ();

    td4_cpu_top #(.PROGRAM(C_PROG_DEF))  dut0 (.clock(clock), .reset(reset), .io(io0.slave));
    td4_cpu_top #(.PROGRAM(C_PROG_CUST)) dut1 (.clock(clock), .reset(reset), .io(io1.slave));
    td4_cpu_top #(.PROGRAM(C_PROG_NOP))  dut2 (.clock(clock), .reset(reset), .io(io2.slave));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic st_t model_step(input logic [127:0] prog, input st_t s, input logic [3:0] swv);
        st_t        n;
        logic [7:0] ins;
        logic [4:0] t;
        n    = s;
        ins  = prog[s.pc*8 +: 8];
        n.pc = s.pc + 4'd1;
        n.c  = 1'b0;
        t    = 5'd0;
        case (ins[7:4])
            4'h0: begin t = {1'b0, s.a} + {1'b0, ins[3:0]}; n.a = t[3:0]; n.c = t[4]; end
            4'h1: n.a = s.b;
            4'h2: n.a = swv;
            4'h3: n.a = ins[3:0];
            4'h4: n.b = s.a;
            4'h5: begin t = {1'b0, s.b} + {1'b0, ins[3:0]}; n.b = t[3:0]; n.c = t[4]; end
            4'h6: n.b = swv;
            4'h7: n.b = ins[3:0];
            4'h9: n.out = s.b;
            4'hB: n.out = ins[3:0];
            4'hE: if (!s.c) n.pc = ins[3:0];
            4'hF: n.pc = ins[3:0];
            default: ;
        endcase
        return n;
    endfunction

    function automatic st_t dut_state(input int k);
        st_t s;
        case (k)
            0:       s = '{dut0.r_pc, dut0.r_a, dut0.r_b, io0.LED, dut0.r_c};
            1:       s = '{dut1.r_pc, dut1.r_a, dut1.r_b, io1.LED, dut1.r_c};
            default: s = '{dut2.r_pc, dut2.r_a, dut2.r_b, io2.LED, dut2.r_c};
        endcase
        return s;
    endfunction

    // Predict the edge for every CPU, push, let the edge happen, then pop and compare.
    task automatic tick();
        st_t got;
        st_t e;
        for (int k = 0; k < 3; k++) begin
            m[k] = (reset === 1'b1) ? model_step(progs[k], m[k], io0.sw) : '0;
            exp_q.push_back(m[k]);
        end
        @(posedge clock);
        #1;
        for (int k = 0; k < 3; k++) begin
            got = dut_state(k);
            e   = exp_q.pop_front();
            check_eq($sformatf("state_cpu%0d", k), 32'(got), 32'(e));
        end
    endtask

    task automatic default_run_checks(input int n);
        case (n)
            3:  check_eq("led_e3",  32'(io0.LED), 32'hA);
            7:  check_eq("led_e7",  32'(io0.LED), 32'hB);
            23: check_eq("led_e23", 32'(io0.LED), 32'hF);
            24: begin
                check_eq("a_e24", 32'(dut0.r_a), 32'h0);
                check_eq("c_e24", 32'(dut0.r_c), 32'h1);
            end
            25: check_eq("pc_e25_jnc_not_taken", 32'(dut0.r_pc), 32'h5);
            26: check_eq("led_e26_outf", 32'(io0.LED), 32'hF);
            40: begin
                check_eq("led_loop", 32'(io0.LED), 32'hF);
                check_eq("c_loop",   32'(dut0.r_c), 32'h0);
            end
            default: ;
        endcase
    endtask

    task automatic other_run_checks(input int n);
        case (n)
            2: begin
                check_eq("cust_a_e2", 32'(dut1.r_a), 32'h1);
                check_eq("cust_c_e2", 32'(dut1.r_c), 32'h1);
            end
            3:  check_eq("cust_pc_e3", 32'(dut1.r_pc), 32'h3);
            4:  check_eq("cust_led_e4", 32'(io1.LED), 32'h5);
            16: check_eq("nop_pc_wrap", 32'(dut2.r_pc), 32'h0);
            17: begin
                check_eq("nop_pc_after_wrap", 32'(dut2.r_pc), 32'h1);
                check_eq("nop_led", 32'(io2.LED), 32'h0);
                check_eq("nop_a",   32'(dut2.r_a), 32'h0);
            end
            default: ;
        endcase
    endtask

    initial begin
        progs[0] = C_PROG_DEF;
        progs[1] = C_PROG_CUST;
        progs[2] = C_PROG_NOP;
        for (int k = 0; k < 3; k++) m[k] = '0;
        io0.sw = 4'b1010;
        io1.sw = 4'b1010;
        io2.sw = 4'b1010;
        reset  = 1'bx;

        #2 reset = 1'b0;
        #1;
        check_eq("reset_led", 32'(io0.LED), 32'h0);
        check_eq("reset_pc",  32'(dut0.r_pc), 32'h0);
        tick();
        tick();

        reset = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            default_run_checks(n);
            other_run_checks(n);
        end

        #1 reset = 1'b0;
        #1;
        check_eq("midloop_reset_led", 32'(io0.LED), 32'h0);
        check_eq("midloop_reset_pc",  32'(dut0.r_pc), 32'h0);
        for (int k = 0; k < 3; k++) m[k] = '0;
        tick();

        reset = 1'b1;
        for (int n = 1; n <= 26; n++) begin
            tick();
            default_run_checks(n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
